// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, data-enable, counters, active-area
// coordinates, line/frame strobes and a frame counter, all advancing on the pixel ce.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter int unsigned HS_POL   = 0,
  parameter int unsigned VS_POL   = 0,
  parameter int unsigned CW       = 11,
  parameter int unsigned FCW      = 8
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           ce,
  output logic           hsync,
  output logic           vsync,
  output logic           vidon,
  output logic [CW-1:0]  hc,
  output logic [CW-1:0]  vc,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           sol,
  output logic           sof,
  output logic [FCW-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_C = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_C = CW'(V_SYNC);
  localparam logic [CW-1:0] H_START  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_END    = CW'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [CW-1:0] V_START  = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_END    = CW'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic          HS_ON    = (HS_POL != 0);
  localparam logic          VS_ON    = (VS_POL != 0);

  logic [CW-1:0]  h_cnt_q, h_cnt_d;
  logic [CW-1:0]  v_cnt_q, v_cnt_d;
  logic [FCW-1:0] frame_q, frame_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           vidon_q, vidon_d;
  logic [CW-1:0]  hc_q, hc_d;
  logic [CW-1:0]  vc_q, vc_d;
  logic [CW-1:0]  x_q, x_d;
  logic [CW-1:0]  y_q, y_d;
  logic           sol_q, sol_d;
  logic           sof_q, sof_d;

  logic h_wrap, v_wrap, h_vis, v_vis;

  // Outputs are decoded from the pre-increment counters so every output
  // registered on a given ce edge describes the same pixel.
  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_vis   = (h_cnt_q >= H_START) && (h_cnt_q <= H_END);
    v_vis   = (v_cnt_q >= V_START) && (v_cnt_q <= V_END);

    h_cnt_d = h_wrap ? '0 : h_cnt_q + CW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + CW'(1);
    end
    frame_d = (h_wrap && v_wrap) ? frame_q + FCW'(1) : frame_q;

    hc_d    = h_cnt_q;
    vc_d    = v_cnt_q;
    hsync_d = (h_cnt_q < H_SYNC_C) ? HS_ON : ~HS_ON;
    vsync_d = (v_cnt_q < V_SYNC_C) ? VS_ON : ~VS_ON;
    vidon_d = h_vis && v_vis;
    x_d     = vidon_d ? h_cnt_q - H_START : '0;
    y_d     = vidon_d ? v_cnt_q - V_START : '0;
    sol_d   = (h_cnt_q == '0);
    sof_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      frame_q <= '0;
      hc_q    <= '0;
      vc_q    <= '0;
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      vidon_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      sol_q   <= 1'b0;
      sof_q   <= 1'b0;
    end else if (ce) begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      frame_q <= frame_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      vidon_q <= vidon_d;
      x_q     <= x_d;
      y_q     <= y_d;
      sol_q   <= sol_d;
      sof_q   <= sof_d;
    end
  end

  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign vidon     = vidon_q;
  assign hc        = hc_q;
  assign vc        = vc_q;
  assign x         = x_q;
  assign y         = y_q;
  assign sol       = sol_q;
  assign sof       = sof_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 800x600 mode, a tiny mode for frame wrap and ce gating,
// and 640x480 with positive sync polarity, each held in reset while idle.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic clr_d = 1'b1, ce_d = 1'b1;
  logic clr_s = 1'b1, ce_s = 1'b1;
  logic clr_a = 1'b1, ce_a = 1'b1;

  logic        d_hs, d_vs, d_vo, d_sol, d_sof;
  logic [10:0] d_hc, d_vc, d_x, d_y;
  logic [7:0]  d_fc;
  logic        s_hs, s_vs, s_vo, s_sol, s_sof;
  logic [10:0] s_hc, s_vc, s_x, s_y;
  logic [1:0]  s_fc;
  logic        a_hs, a_vs, a_vo, a_sol, a_sof;
  logic [10:0] a_hc, a_vc, a_x, a_y;
  logic [7:0]  a_fc;

  vga_timing_gen u_def (
    .clk(clk), .clr(clr_d), .ce(ce_d),
    .hsync(d_hs), .vsync(d_vs), .vidon(d_vo), .hc(d_hc), .vc(d_vc),
    .x(d_x), .y(d_y), .sol(d_sol), .sof(d_sof), .frame_cnt(d_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(0), .VS_POL(0), .CW(11), .FCW(2)
  ) u_sm (
    .clk(clk), .clr(clr_s), .ce(ce_s),
    .hsync(s_hs), .vsync(s_vs), .vidon(s_vo), .hc(s_hc), .vc(s_vc),
    .x(s_x), .y(s_y), .sol(s_sol), .sof(s_sof), .frame_cnt(s_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(480), .V_FP(10), .V_SYNC(2), .V_BP(33),
    .HS_POL(1), .VS_POL(1), .CW(11), .FCW(8)
  ) u_alt (
    .clk(clk), .clr(clr_a), .ce(ce_a),
    .hsync(a_hs), .vsync(a_vs), .vidon(a_vo), .hc(a_hc), .vc(a_vc),
    .x(a_x), .y(a_y), .sol(a_sol), .sof(a_sof), .frame_cnt(a_fc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  int unsigned hs, vs, vo, sl, sf, cnt;
  logic        got;

  initial begin
    // ---------------- default 800x600 ----------------
    tick(2);
    chk("rst_hc", 32'(d_hc), 0);
    chk("rst_vc", 32'(d_vc), 0);
    chk("rst_x", 32'(d_x), 0);
    chk("rst_y", 32'(d_y), 0);
    chk("rst_vidon", 32'(d_vo), 0);
    chk("rst_sol", 32'(d_sol), 0);
    chk("rst_sof", 32'(d_sof), 0);
    chk("rst_hsync", 32'(d_hs), 1);
    chk("rst_vsync", 32'(d_vs), 1);
    chk("rst_fc", 32'(d_fc), 0);

    clr_d = 1'b0;
    tick(1);
    chk("p0_hc", 32'(d_hc), 0);
    chk("p0_vc", 32'(d_vc), 0);
    chk("p0_hsync", 32'(d_hs), 0);
    chk("p0_vsync", 32'(d_vs), 0);
    chk("p0_sol", 32'(d_sol), 1);
    chk("p0_sof", 32'(d_sof), 1);
    chk("p0_vidon", 32'(d_vo), 0);
    tick(1);
    chk("p1_hc", 32'(d_hc), 1);
    chk("p1_sol", 32'(d_sol), 0);
    chk("p1_sof", 32'(d_sof), 0);

    hs = 0; vs = 0; vo = 0; sl = 0; sf = 0;
    for (int i = 0; i < 28726; i++) begin
      tick(1);
      if (!d_hs) hs++;
      if (!d_vs) vs++;
      if (d_vo) vo++;
      if (d_sol) sl++;
      if (d_sof) sf++;
    end
    chk("def_hsync_low", hs, 3582);
    chk("def_vsync_low", vs, 4222);
    chk("def_vidon_rows0_26", vo, 0);
    chk("def_sol_count", sl, 27);
    chk("def_sof_count", sf, 0);
    chk("h215_hc", 32'(d_hc), 215);
    chk("h215_vc", 32'(d_vc), 27);
    chk("h215_vidon", 32'(d_vo), 0);
    tick(1);
    chk("h216_vidon", 32'(d_vo), 1);
    chk("h216_x", 32'(d_x), 0);
    chk("h216_y", 32'(d_y), 0);
    tick(799);
    chk("h1015_hc", 32'(d_hc), 1015);
    chk("h1015_vidon", 32'(d_vo), 1);
    chk("h1015_x", 32'(d_x), 799);
    tick(1);
    chk("h1016_vidon", 32'(d_vo), 0);
    chk("h1016_x", 32'(d_x), 0);

    tick(540);
    chk("mid_hc", 32'(d_hc), 500);
    chk("mid_vc", 32'(d_vc), 28);
    chk("mid_x", 32'(d_x), 284);
    chk("mid_y", 32'(d_y), 1);
    clr_d = 1'b1;
    #1;
    chk("async_hc", 32'(d_hc), 0);
    chk("async_vc", 32'(d_vc), 0);
    chk("async_x", 32'(d_x), 0);
    chk("async_vidon", 32'(d_vo), 0);
    chk("async_hsync", 32'(d_hs), 1);
    chk("async_sol", 32'(d_sol), 0);
    tick(1);
    clr_d = 1'b0;
    tick(1);
    chk("restart_hc", 32'(d_hc), 0);
    chk("restart_vc", 32'(d_vc), 0);
    chk("restart_sof", 32'(d_sof), 1);
    chk("restart_fc", 32'(d_fc), 0);
    tick(1);
    chk("restart_hc1", 32'(d_hc), 1);
    clr_d = 1'b1;

    // ---------------- tiny mode: 15x11 total, FCW=2 ----------------
    clr_s = 1'b0;
    tick(1);
    chk("s_p0_sof", 32'(s_sof), 1);
    chk("s_p0_hsync", 32'(s_hs), 0);
    chk("s_p0_vsync", 32'(s_vs), 0);
    chk("s_p0_fc", 32'(s_fc), 0);
    hs = 0; vs = 0; vo = 0; cnt = 0; got = 1'b0;
    while (cnt < 400 && !got) begin
      tick(1);
      cnt++;
      if (!s_hs) hs++;
      if (!s_vs) vs++;
      if (s_vo) vo++;
      if (cnt == 59) chk("s_vc3_end_vidon", 32'(s_vo), 0);
      if (cnt == 65) begin
        chk("s_vstart_vidon", 32'(s_vo), 1);
        chk("s_vstart_y", 32'(s_y), 0);
      end
      if (cnt == 140) begin
        chk("s_vend_vidon", 32'(s_vo), 1);
        chk("s_vend_y", 32'(s_y), 5);
      end
      if (cnt == 147) chk("s_hend_x", 32'(s_x), 7);
      if (cnt == 148) chk("s_after_hend_vidon", 32'(s_vo), 0);
      if (cnt == 163) begin
        chk("s_lastrow_vc", 32'(s_vc), 10);
        chk("s_lastrow_vidon", 32'(s_vo), 0);
        chk("s_fc_before_wrap", 32'(s_fc), 0);
      end
      if (s_sof) got = 1'b1;
    end
    chk("s_sof_seen", 32'(got), 1);
    chk("s_sof_period", cnt, 165);
    chk("s_fc_after_frame", 32'(s_fc), 1);
    chk("s_hsync_low", hs, 33);
    chk("s_vsync_low", vs, 30);
    chk("s_vidon_pixels", vo, 48);
    tick(330);
    chk("s_fc3", 32'(s_fc), 3);
    tick(165);
    chk("s_fc_wrap_sof", 32'(s_sof), 1);
    chk("s_fc_wrap", 32'(s_fc), 0);

    ce_s = 1'b0;
    tick(1);
    chk("s_hold_sof", 32'(s_sof), 1);
    chk("s_hold_sol", 32'(s_sol), 1);
    chk("s_hold_hc", 32'(s_hc), 0);
    chk("s_hold_vc", 32'(s_vc), 0);
    cnt = 1; got = 1'b0; sl = 0; sf = 0;
    while (cnt < 1000 && !got) begin
      ce_s = ~ce_s;
      tick(1);
      cnt++;
      if (!ce_s && s_sol) sl++;
      if (ce_s && s_sol) sf++;
      if (ce_s && s_sof) got = 1'b1;
    end
    chk("s_half_sof_seen", 32'(got), 1);
    chk("s_half_sof_period", cnt, 330);
    chk("s_half_sol_held", sl, 10);
    chk("s_half_sol_edges", sf, 11);
    ce_s  = 1'b1;
    clr_s = 1'b1;

    // ---------------- 640x480, positive sync ----------------
    chk("a_rst_hsync", 32'(a_hs), 0);
    chk("a_rst_vsync", 32'(a_vs), 0);
    clr_a = 1'b0;
    tick(1);
    chk("a_p0_hsync", 32'(a_hs), 1);
    chk("a_p0_vsync", 32'(a_vs), 1);
    chk("a_p0_sof", 32'(a_sof), 1);
    hs = 0; vs = 0; vo = 0; sl = 0;
    for (int i = 0; i < 28143; i++) begin
      tick(1);
      if (a_hs) hs++;
      if (a_vs) vs++;
      if (a_vo) vo++;
      if (a_sol) sl++;
    end
    chk("a_hsync_high", hs, 3455);
    chk("a_vsync_high", vs, 1599);
    chk("a_vidon_rows0_34", vo, 0);
    chk("a_sol_count", sl, 35);
    chk("a_h143_hc", 32'(a_hc), 143);
    chk("a_h143_vc", 32'(a_vc), 35);
    chk("a_h143_vidon", 32'(a_vo), 0);
    tick(1);
    chk("a_h144_vidon", 32'(a_vo), 1);
    chk("a_h144_x", 32'(a_x), 0);
    chk("a_h144_y", 32'(a_y), 0);
    tick(639);
    chk("a_h783_vidon", 32'(a_vo), 1);
    chk("a_h783_x", 32'(a_x), 639);
    tick(1);
    chk("a_h784_vidon", 32'(a_vo), 0);
    chk("a_h784_x", 32'(a_x), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
